// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types for the FIFO
// read-side burst controller.
package sync_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  // Timer width; a zero timeout still
  // needs a one-bit (constant) timer.
  function automatic int tmr_w(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: single-entry valid/ready
// register slice with synchronous clear.
// Ports: clk, rst (async, high), clear,
//   s_data/s_valid/s_ready (upstream),
//   m_data/m_valid/m_ready (downstream).
module stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (clear) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// sync_fifo_burst_reader: drains sync_fifo in
// framed bursts (full, timeout or flush).
// Ports: clk, rst (async, high);
//   in_data/in_valid/in_ready, fifo_count
//   from/to the FIFO read port;
//   flush, clear controls;
//   out_data/out_valid/out_ready,
//   out_first/out_last framed stream; busy.
module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 256,
  parameter int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN     = 16,
  parameter int TIMEOUT       = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LB_FIFO_DEPTH:0] fifo_count,
  input  logic                   flush,
  input  logic                   clear,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   busy
);

  localparam int CW = LB_FIFO_DEPTH + 1;
  localparam int TW = tmr_w(TIMEOUT);
  localparam logic [CW-1:0] BL =
    CW'(BURST_LEN);
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  burst_state_e state, state_n;

  logic [CW-1:0] len;
  logic [CW-1:0] remaining;
  logic [CW-1:0] start_len;
  logic [TW-1:0] timer;

  logic full_go;
  logic part_go;
  logic start;
  logic s_ready;
  logic in_fire;
  logic out_fire;
  logic beat_first;
  logic beat_last;

  logic [DATA_WIDTH+1:0] s_pl;
  logic [DATA_WIDTH+1:0] m_pl;

  assign full_go = fifo_count >= BL;
  assign part_go = (fifo_count != '0) &&
    (flush || (TIMEOUT != 0 && timer == TMAX));
  // Full bursts take priority; clear wins
  // over any start.
  assign start = (state == IDLE) && !clear &&
    (full_go || part_go);
  assign start_len = full_go ? BL : fifo_count;

  assign busy = (state == BURST);

  // Gated by clear so an abort never pops a
  // word that would then be dropped.
  assign in_ready = busy && !clear &&
    (remaining != '0) && s_ready;
  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;

  assign beat_first = (remaining == len);
  assign beat_last  = (remaining == CW'(1));
  assign s_pl = {in_data, beat_first, beat_last};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start) state_n = BURST;
      BURST:
        if (clear || (out_fire && out_last))
          state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      remaining <= '0;
      timer     <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        len       <= start_len;
        remaining <= start_len;
      end else if (in_fire) begin
        remaining <= remaining - 1'b1;
      end
      if (clear || start || busy ||
          fifo_count == '0)
        timer <= '0;
      else if (timer != TMAX)
        timer <= timer + 1'b1;
    end
  end

  stream_reg_slice #(
    .W(DATA_WIDTH + 2)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .s_data  (s_pl),
    .s_valid (in_fire),
    .s_ready (s_ready),
    .m_data  (m_pl),
    .m_valid (out_valid),
    .m_ready (out_ready)
  );

  assign {out_data, out_first, out_last} = m_pl;

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// tb_sync_fifo_burst_reader: FIFO model plus
// burst-framing reference checks.
module tb_sync_fifo_burst_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LB    = 4;
  localparam int BL    = 4;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LB:0]   fifo_count = '0;
  logic          flush = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_first;
  logic          out_last;
  logic          busy;

  int errs = 0;
  int nchk = 0;

  logic [7:0] fq[$];
  logic [7:0] push_q[$];
  logic [7:0] sb[$];
  logic [9:0] cap[$];

  typedef struct {
    int         n;
    logic [7:0] base;
    logic       fl;
    int         lat;
  } vec_t;
  vec_t vec[6];

  sync_fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_count (fifo_count),
    .flush      (flush),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n,
                      input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push_q.push_back(base + 8'(i));
      sb.push_back(base + 8'(i));
    end
  endtask

  task automatic wait_valid(input string nm,
                            input int budget,
                            output int lat);
    bit done;
    done = 0;
    lat = 0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (out_valid) done = 1;
      else begin
        step();
        flush = 1'b0;
        lat++;
      end
    end
    chk(nm, 32'(done), 1);
  endtask

  task automatic wait_idle(input string nm,
                           input int budget);
    bit done;
    done = 0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (!busy && !out_valid) done = 1;
    end
    chk(nm, 32'(done), 1);
    step();
  endtask

  // FIFO model: registered count/head,
  // pops on the reader's handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      push_q.delete();
    end else begin
      if (in_ready && in_valid) fq.delete(0);
      while (push_q.size() > 0)
        fq.push_back(push_q.pop_front());
    end
    fifo_count <= 5'(fq.size());
    in_valid   <= (fq.size() != 0);
    in_data    <= (fq.size() != 0) ? fq[0] : '0;
  end

  // Reference rules: start/stop of bursts,
  // framing, data order and output hold.
  logic       prev_ok = 1'b0;
  logic       p_busy, p_valid, p_ready;
  logic       p_first, p_last, p_clear, p_start;
  logic [7:0] p_data;
  int         p_count;
  int         wait_run = 0;
  int         beat_idx = 0;
  int         cur_len = BL;

  always @(negedge clk) begin
    if (rst) begin
      prev_ok  = 1'b0;
      wait_run = 0;
      beat_idx = 0;
      sb.delete();
    end else begin
      if (prev_ok) begin
        if (p_clear) begin
          chk("m_clr_busy", 32'(busy), 0);
          chk("m_clr_vld", 32'(out_valid), 0);
        end else begin
          if (!p_busy)
            chk("m_start", 32'(busy), 32'(p_start));
          else
            chk("m_burst_end", 32'(busy),
                32'(!(p_valid && p_ready && p_last)));
          if (p_valid && !p_ready)
            chk("m_hold",
                {out_valid, out_data, out_first, out_last},
                {1'b1, p_data, p_first, p_last});
        end
        if (!p_busy && busy) begin
          cur_len  = (p_count < BL) ? p_count : BL;
          beat_idx = 0;
        end
      end
      if (!busy) chk("m_idle_rdy", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        cap.push_back({out_data, out_first, out_last});
        if (sb.size() == 0) begin
          nchk++;
          errs++;
          $display("FAIL m_extra: got beat 0x%0h want none",
                   out_data);
        end else begin
          chk("m_data", 32'(out_data), 32'(sb.pop_front()));
        end
        if (prev_ok) begin
          chk("m_first", 32'(out_first),
              32'(beat_idx == 0));
          chk("m_last", 32'(out_last),
              32'(beat_idx == cur_len - 1));
        end
        beat_idx++;
        if (out_last) beat_idx = 0;
      end
      if (clear) beat_idx = 0;
      p_start = !clear && !busy && fifo_count != 0 &&
        (fifo_count >= BL || flush || wait_run == TO - 1);
      if (clear || busy || fifo_count == 0 || p_start)
        wait_run = 0;
      else if (wait_run < TO - 1)
        wait_run++;
      p_busy  = busy;
      p_valid = out_valid;
      p_ready = out_ready;
      p_first = out_first;
      p_last  = out_last;
      p_data  = out_data;
      p_clear = clear;
      p_count = int'(fifo_count);
      prev_ok = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    int n;
    logic [7:0] b;

    vec[0] = '{4, 8'h10, 1'b0, 2};
    vec[1] = '{3, 8'hA0, 1'b0, 9};
    vec[2] = '{2, 8'h30, 1'b1, 2};
    vec[3] = '{1, 8'h38, 1'b1, 2};
    vec[4] = '{1, 8'h3C, 1'b0, 9};
    vec[5] = '{4, 8'h20, 1'b1, 2};

    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_first", 32'(out_first), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_inrdy", 32'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 6; v++) begin
      n = vec[v].n;
      b = vec[v].base;
      cap.delete();
      load(n, b);
      step();
      flush = vec[v].fl;
      wait_valid("vec_wait", 20, lat);
      flush = 1'b0;
      chk("vec_lat", 32'(lat), 32'(vec[v].lat));
      wait_idle("vec_idle", 20);
      chk("vec_beats", 32'(cap.size()), 32'(n));
      if (cap.size() == n) begin
        chk("vec_b0", 32'(cap[0]),
            {22'd0, b, 1'b1, n == 1});
        chk("vec_bn", 32'(cap[n-1]),
            {22'd0, b + 8'(n - 1), n == 1, 1'b1});
      end
      repeat (3) step();
    end

    cap.delete();
    load(4, 8'h40);
    step();
    chk("stall_cnt0", 32'(fifo_count), 4);
    got = 0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (out_valid && out_data == 8'h41) got = 1;
      else step();
    end
    chk("stall_wait", 32'(got), 1);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_data", 32'(out_data), 32'h42);
      chk("stall_vld", 32'(out_valid), 1);
      chk("stall_inrdy", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    wait_idle("stall_idle", 20);
    chk("stall_beats", 32'(cap.size()), 4);
    chk("stall_cnt1", 32'(fifo_count), 0);
    if (cap.size() == 4) begin
      chk("stall_b2", 32'(cap[2]), {22'd0, 8'h42, 2'b00});
      chk("stall_b3", 32'(cap[3]), {22'd0, 8'h43, 2'b01});
    end

    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fl0_busy", 32'(busy), 0);
      step();
    end

    cap.delete();
    load(4, 8'h50);
    step();
    got = 0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (out_valid && out_first) got = 1;
      else step();
    end
    chk("clr_wait", 32'(got), 1);
    step();
    chk("clr_b1", 32'(out_data), 32'h51);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_vld", 32'(out_valid), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_fl", {30'd0, out_first, out_last}, 0);
    chk("clr_cnt", 32'(fifo_count), 2);
    chk("clr_cap", 32'(cap.size()), 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("clr_w2", 10, lat);
    wait_idle("clr_idle", 20);
    chk("clr_beats", 32'(cap.size()), 4);
    if (cap.size() == 4) begin
      chk("clr_n0", 32'(cap[2]), {22'd0, 8'h52, 2'b10});
      chk("clr_n1", 32'(cap[3]), {22'd0, 8'h53, 2'b01});
    end

    repeat (2) step();
    load(4, 8'h60);
    step();
    wait_valid("rmb_wait", 10, lat);
    #2 rst = 1'b1;
    #1;
    chk("rmb_vld", 32'(out_valid), 0);
    chk("rmb_data", 32'(out_data), 0);
    chk("rmb_first", 32'(out_first), 0);
    chk("rmb_last", 32'(out_last), 0);
    chk("rmb_busy", 32'(busy), 0);
    chk("rmb_inrdy", 32'(in_ready), 0);
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rmb_hold",
          {29'd0, busy, out_valid, in_ready}, 0);
      step();
    end

    for (int c = 0; c < 1500; c++) begin
      int room;
      int k;
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        room = DEPTH - int'(fifo_count) - push_q.size();
        k = $urandom_range(1, 3);
        if (k > room) k = room;
        for (int i = 0; i < k; i++) begin
          b = 8'($urandom);
          push_q.push_back(b);
          sb.push_back(b);
        end
      end
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;

    got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (fq.size() == 0 && !busy && !out_valid)
        got = 1;
      else step();
    end
    chk("drain_done", 32'(got), 1);
    chk("drain_sb", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, nchk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_burst_reader.md
# sync_fifo_burst_reader

Read-side controller that sits on the output port of `sync_fifo` and drains it in framed bursts. It watches the FIFO fill level and issues a burst when `BURST_LEN` words are available, or a shorter burst when data has waited `TIMEOUT` cycles or `flush` is pulsed. Each burst is forwarded through a registered valid/ready output with first/last markers, so downstream packetizers get framed transfers instead of a raw word stream.

## Interface
- `DATA_WIDTH`, 8, word width, equal to the FIFO's `DATA_WIDTH`.
- `FIFO_DEPTH`, 256, depth of the FIFO being drained.
- `LB_FIFO_DEPTH`, `$clog2(FIFO_DEPTH)`, address width; count width is `LB_FIFO_DEPTH+1`.
- `BURST_LEN`, 16, full burst length; legal range is 1..`FIFO_DEPTH`.
- `TIMEOUT`, 64, number of idle cycles before a partial burst; 0 disables timeout flushing.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  `DATA_WIDTH`  word from the FIFO's `out_data`.
- `in_valid`  in  1  from the FIFO's `out_valid`.
- `in_ready`  out  1  to the FIFO's `out_ready`.
- `fifo_count`  in  `LB_FIFO_DEPTH+1`  from the FIFO's `count`.
- `flush`  in  1  single-cycle request to start a partial burst.
- `clear`  in  1  synchronous abort back to idle.
- `out_data`  out  `DATA_WIDTH`  registered burst data.
- `out_valid`  out  1  output data valid.
- `out_ready`  in  1  downstream ready.
- `out_first`  out  1  marks beat 0 of a burst.
- `out_last`  out  1  marks the final beat of a burst.
- `busy`  out  1  high while a burst is in progress (state is BURST).

## Operation
- FSM states are `IDLE` and `BURST`.
- In `IDLE`:
  - If `fifo_count >= BURST_LEN`, latch `len = BURST_LEN` and go to `BURST`.
  - Else if `fifo_count != 0` and (`flush` is high, or `timer == TIMEOUT-1` with `TIMEOUT != 0`), latch `len = fifo_count` and go to `BURST`.
  - The full-burst condition has priority over the partial-burst condition.
- Timer:
  - Increments in `IDLE` while `fifo_count != 0`.
  - Clears when `fifo_count == 0`, when a burst starts, and on `clear`.
  - Saturates at `TIMEOUT-1`.
- In `BURST`:
  - `in_ready = (remaining != 0) && (!out_valid || out_ready)`.
  - Each input handshake loads the output register and decrements `remaining`, which starts at `len`.
  - `out_first` is set on the beat where `remaining == len`; `out_last` is set on the beat where `remaining == 1`.
  - The FSM returns to `IDLE` on the output handshake of the `out_last` beat.
- `in_ready` is 0 in `IDLE`.
- `len` needs no re-check during the burst: only this block reads the FIFO, so the snapshot never exceeds the data available.
- The output register holds `out_data`, `out_first` and `out_last` stable while `out_valid && !out_ready`.
- `clear`: FSM goes to `IDLE`, `out_valid`, `out_first` and `out_last` go to 0, and the timer goes to 0. A partial burst is abandoned with no `out_last`. FIFO contents are untouched; pair this with the FIFO's own `clear` if data must be dropped.
- `flush` while `fifo_count == 0` or while in `BURST` is ignored and not queued.

## Timing
- Reset values: `out_valid`, `out_data`, `out_first`, `out_last`, `busy` and `in_ready` are all 0; FSM is `IDLE`, timer is 0.
- Start condition true in cycle N gives `busy` = 1 and `in_ready` possibly 1 in N+1, and first `out_valid` in N+2.
- Input-to-output latency is 1 cycle.
- Throughput is 1 beat per cycle with `out_ready` held high.
- There is one idle cycle between back-to-back bursts (the `IDLE` evaluation cycle).
- Simultaneous `clear` and start condition: `clear` wins.
- Simultaneous `clear` and an output handshake: the beat is considered delivered and the register is emptied.
- Reset asserted mid-burst: all outputs drop immediately (asynchronously) to their reset values.
- Counter widths: `len` and `remaining` are `LB_FIFO_DEPTH+1` bits; the timer is `$clog2(TIMEOUT+1)` bits.

## Structure
- Shared package `sync_fifo_pkg` holds the FSM typedef `burst_state_e` (`IDLE`, `BURST`).
- One sub-module, `stream_reg_slice`: a single-entry output register carrying {data, first, last} with valid/ready. It is parameterised by payload width and reused elsewhere in the design.

## Test plan
- `BURST_LEN=4`, FIFO loaded with 0x10..0x13, `out_ready=1`: four beats in consecutive cycles; `out_first` on 0x10, `out_last` on 0x13; first `out_valid` 2 cycles after `fifo_count` reaches 4.
- `TIMEOUT=8`, 3 words 0xA0..0xA2 written then idle: burst of length 3 starts 8 cycles after `fifo_count` becomes nonzero; `out_last` on 0xA2.
- Full burst with `out_ready` low for 5 cycles on beat 2: `out_data` held stable, `in_ready=0`, no beat lost or duplicated, FIFO count decrements by exactly 4 in total.
- `fifo_count=2` with `flush` pulsed: 2-beat burst; `flush` pulsed again with `fifo_count=0`: no burst, `busy` stays 0.
- `clear` on beat 1 of a 4-beat burst: next cycle `out_valid=0` and `busy=0`; a subsequent burst of the remaining 2 words begins correctly with `out_first`.
- `rst` asserted mid-burst: `out_valid`, `out_first`, `out_last`, `busy` and `in_ready` are 0 immediately and stay 0 until the first start condition after reset release.
